// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared definitions for the fifo write arbiter: FSM state encoding and burst counter width.
package fifo_wr_arbiter_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  localparam int BEAT_CNT_W = 8;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin selector: first valid requester after last_grant, wrapping modulo num_req.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDW     = 2
) (
  input  logic [NUM_REQ-1:0] i_req_valid,
  input  logic [IDW-1:0]     i_last_grant,
  output logic [IDW-1:0]     o_next,
  output logic               o_any_valid
);

  // Walk offsets from farthest to nearest so the nearest valid requester is written last and wins.
  always_comb begin
    o_next      = '0;
    o_any_valid = 1'b0;
    for (int off = NUM_REQ; off >= 1; off--) begin
      if (i_req_valid[(int'(i_last_grant) + off) % NUM_REQ]) begin
        o_next      = IDW'((int'(i_last_grant) + off) % NUM_REQ);
        o_any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Burst-limited round-robin arbiter sharing one fifo write port among NUM_REQ valid/ready producers.
// Optional per-producer beat and stall statistics are enabled by defining ARB_STATS_EN.
module fifo_wr_arbiter
  import fifo_wr_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REQ    = 4,
  parameter int MAX_BURST  = 4,
  parameter int GID_W      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic [NUM_REQ-1:0]            i_req_valid,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data,
  output logic [NUM_REQ-1:0]            o_req_ready,
  output logic                          o_fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         o_fifo_din,
  input  logic                          i_fifo_full,
`ifdef ARB_STATS_EN
  output logic [NUM_REQ*16-1:0]         o_beat_count,
  output logic [15:0]                   o_stall_cycles,
`endif
  output logic [GID_W-1:0]              o_grant_id,
  output logic                          o_busy
);

  localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(MAX_BURST - 1);

  state_t                  r_state;
  logic [GID_W-1:0]        r_grant_id;
  logic [GID_W-1:0]        r_last_grant;
  logic [BEAT_CNT_W-1:0]   r_beat_cnt;

  logic [GID_W-1:0]        w_next;
  logic                    w_any_valid;
  logic                    w_ready;
  logic                    w_grant_valid;
  logic                    w_xfer;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDW     (GID_W)
  ) u_rr_pick (
    .i_req_valid  (i_req_valid),
    .i_last_grant (r_last_grant),
    .o_next       (w_next),
    .o_any_valid  (w_any_valid)
  );

  assign w_ready       = (r_state == BURST) && !i_fifo_full;
  assign w_grant_valid = i_req_valid[r_grant_id];
  assign w_xfer        = w_ready && w_grant_valid;

  assign o_fifo_wr_en = w_xfer;
  assign o_fifo_din   = i_req_data[int'(r_grant_id)*DATA_WIDTH +: DATA_WIDTH];
  assign o_grant_id   = r_grant_id;
  assign o_busy       = (r_state == BURST);

  always_comb begin
    o_req_ready = '0;
    if (w_ready) o_req_ready[r_grant_id] = 1'b1;
  end

  // A full fifo freezes the burst entirely; only an empty producer or the burst limit ends it.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= IDLE;
      r_grant_id   <= '0;
      r_last_grant <= GID_W'(NUM_REQ - 1);
      r_beat_cnt   <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any_valid) begin
            r_grant_id   <= w_next;
            r_last_grant <= w_next;
            r_beat_cnt   <= '0;
            r_state      <= BURST;
          end
        end
        BURST: begin
          if (w_xfer) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
            if (r_beat_cnt == LAST_BEAT) r_state <= IDLE;
          end else if (!i_fifo_full && !w_grant_valid) begin
            r_state <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef ARB_STATS_EN
  logic [NUM_REQ*16-1:0] r_beat_count;
  logic [15:0]           r_stall_cycles;

  // Saturating counters so long runs never wrap back to misleading small values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_beat_count   <= '0;
      r_stall_cycles <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (w_xfer && (r_grant_id == GID_W'(i)) && (r_beat_count[i*16 +: 16] != 16'hFFFF))
          r_beat_count[i*16 +: 16] <= r_beat_count[i*16 +: 16] + 16'd1;
      end
      if ((r_state == BURST) && i_fifo_full && (r_stall_cycles != 16'hFFFF))
        r_stall_cycles <= r_stall_cycles + 16'd1;
    end
  end

  assign o_beat_count   = r_beat_count;
  assign o_stall_cycles = r_stall_cycles;
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter with a queue-based fifo model and per-producer beat lists.
// Builds with or without ARB_STATS_EN.
module tb_fifo_wr_arbiter;

  localparam int DW  = 32;
  localparam int NR  = 4;
  localparam int MB  = 4;
  localparam int PMAX = 16;

  logic            clk;
  logic            rst;
  logic [NR-1:0]   reqValid;
  logic [NR*DW-1:0] reqData;
  logic [NR-1:0]   reqReady;
  logic            fifoWrEn;
  logic [DW-1:0]   fifoDin;
  logic            fifoFull;
  logic [1:0]      grantId;
  logic            busy;
`ifdef ARB_STATS_EN
  logic [NR*16-1:0] beatCount;
  logic [15:0]      stallCycles;
`endif

  fifo_wr_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (NR),
    .MAX_BURST  (MB)
  ) dut (
    .i_clk          (clk),
    .i_rst          (rst),
    .i_req_valid    (reqValid),
    .i_req_data     (reqData),
    .o_req_ready    (reqReady),
    .o_fifo_wr_en   (fifoWrEn),
    .o_fifo_din     (fifoDin),
    .i_fifo_full    (fifoFull),
`ifdef ARB_STATS_EN
    .o_beat_count   (beatCount),
    .o_stall_cycles (stallCycles),
`endif
    .o_grant_id     (grantId),
    .o_busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [DW-1:0] prodMem [NR][PMAX];
  int            prodHead [NR];
  int            prodCnt  [NR];
  logic [DW-1:0] fifoQ [$];
  int            fifoLimit;

  logic          sWr;
  logic [DW-1:0] sDin;
  logic [NR-1:0] sReady;
  logic [1:0]    sGrant;
  logic          sBusy;

  int expWr2   [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 0, 0};
  int expBusy2 [10] = '{0, 1, 1, 1, 1, 0, 1, 1, 1, 0};
  int expWr5   [11] = '{0, 1, 0, 0, 1, 1, 0, 0, 1, 1, 0};

  // Every comparison in the bench goes through here.
  task automatic checkOutput(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic pushBeat(input int p, input logic [DW-1:0] d);
    prodMem[p][prodCnt[p]] = d;
    prodCnt[p]++;
  endtask

  // One clock cycle: drive inputs from the producer and fifo models, sample mid-cycle, then advance.
  task automatic applyStimulus(input logic rstVal);
    rst = rstVal;
    for (int i = 0; i < NR; i++) begin
      reqValid[i] = (prodHead[i] < prodCnt[i]);
      reqData[i*DW +: DW] = reqValid[i] ? prodMem[i][prodHead[i]] : '0;
    end
    fifoFull = (fifoLimit != 0) && (fifoQ.size() >= fifoLimit);
    #1;
    sWr    = fifoWrEn;
    sDin   = fifoDin;
    sReady = reqReady;
    sGrant = grantId;
    sBusy  = busy;
    if (sWr) fifoQ.push_back(sDin);
    for (int i = 0; i < NR; i++)
      if (sReady[i] && reqValid[i]) prodHead[i]++;
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut();
    for (int i = 0; i < NR; i++) begin
      prodHead[i] = 0;
      prodCnt[i]  = 0;
    end
    fifoQ.delete();
    fifoLimit = 0;
    applyStimulus(1'b1);
    applyStimulus(1'b1);
  endtask

  initial begin
    rst = 1'b1;
    reqValid = '0;
    reqData = '0;
    fifoFull = 1'b0;
    fifoLimit = 0;
    for (int i = 0; i < NR; i++) begin
      prodHead[i] = 0;
      prodCnt[i]  = 0;
    end
    @(posedge clk);
    #1;

    $display("[TB] reset then idle");
    resetDut();
    for (int c = 0; c < 10; c++) begin
      applyStimulus(1'b0);
      checkOutput("idle_busy",  32'(sBusy),  32'd0);
      checkOutput("idle_grant", 32'(sGrant), 32'd0);
      checkOutput("idle_ready", 32'(sReady), 32'd0);
      checkOutput("idle_wr",    32'(sWr),    32'd0);
    end

    $display("[TB] single producer");
    resetDut();
    for (int k = 0; k < 6; k++) pushBeat(2, 32'hA0 + k);
    begin
      int beat = 0;
      for (int c = 0; c < 10; c++) begin
        applyStimulus(1'b0);
        checkOutput("single_wr",   32'(sWr),   32'(expWr2[c]));
        checkOutput("single_busy", 32'(sBusy), 32'(expBusy2[c]));
        if (expWr2[c] == 1) begin
          checkOutput("single_din",   sDin,        32'hA0 + beat);
          checkOutput("single_grant", 32'(sGrant), 32'd2);
          checkOutput("single_ready", 32'(sReady), 32'b0100);
          beat++;
        end
      end
    end
    checkOutput("single_count", 32'(fifoQ.size()), 32'd6);
    for (int j = 0; j < 6 && j < fifoQ.size(); j++)
      checkOutput("single_fifo", fifoQ[j], 32'hA0 + j);

    $display("[TB] round robin");
    resetDut();
    for (int i = 0; i < NR; i++)
      for (int k = 0; k < 8; k++) pushBeat(i, 32'hB000_0000 + i*256 + k);
    for (int c = 0; c < 25; c++) begin
      applyStimulus(1'b0);
      checkOutput("rr_wr", 32'(sWr), (c % 5 != 0) ? 32'd1 : 32'd0);
      if (c % 5 != 0) checkOutput("rr_grant", 32'(sGrant), 32'((c / 5) % 4));
    end
    checkOutput("rr_count", 32'(fifoQ.size()), 32'd20);
    for (int j = 0; j < 20 && j < fifoQ.size(); j++)
      checkOutput("rr_fifo", fifoQ[j], 32'hB000_0000 + ((j / 4) % 4)*256 + (j / 16)*4 + (j % 4));

    $display("[TB] backpressure");
    resetDut();
    fifoLimit = 8;
    for (int k = 0; k < 6; k++) fifoQ.push_back(32'hDD);
    for (int k = 0; k < 4; k++) pushBeat(1, 32'hC0 + k);
    for (int c = 0; c < 3; c++) applyStimulus(1'b0);
    checkOutput("bp_filled", 32'(fifoQ.size()), 32'd8);
    for (int c = 0; c < 20; c++) begin
      applyStimulus(1'b0);
      checkOutput("bp_ready", 32'(sReady), 32'd0);
      checkOutput("bp_wr",    32'(sWr),    32'd0);
      checkOutput("bp_grant", 32'(sGrant), 32'd1);
      checkOutput("bp_busy",  32'(sBusy),  32'd1);
    end
    void'(fifoQ.pop_front());
    begin
      int writes = 0;
      for (int c = 0; c < 5; c++) begin
        applyStimulus(1'b0);
        if (sWr) writes++;
      end
      checkOutput("bp_one_write", 32'(writes), 32'd1);
    end
    checkOutput("bp_size", 32'(fifoQ.size()), 32'd8);
    if (fifoQ.size() == 8) begin
      checkOutput("bp_fifo5", fifoQ[5], 32'hC0);
      checkOutput("bp_fifo6", fifoQ[6], 32'hC1);
      checkOutput("bp_fifo7", fifoQ[7], 32'hC2);
    end
    checkOutput("bp_consumed", 32'(prodHead[1]), 32'd3);

    $display("[TB] early end");
    resetDut();
    pushBeat(2, 32'hD2);
    begin
      logic [DW-1:0] expData [5] = '{32'hD2, 32'hE0, 32'hE1, 32'hF0, 32'hF1};
      for (int c = 0; c < 11; c++) begin
        if (c == 3) begin
          pushBeat(3, 32'hE0);
          pushBeat(3, 32'hE1);
          pushBeat(0, 32'hF0);
          pushBeat(0, 32'hF1);
        end
        applyStimulus(1'b0);
        checkOutput("early_wr", 32'(sWr), 32'(expWr5[c]));
        if (c == 1) checkOutput("early_grant2", 32'(sGrant), 32'd2);
        if (c == 4 || c == 5) checkOutput("early_grant3", 32'(sGrant), 32'd3);
        if (c == 7) checkOutput("early_idle", 32'(sBusy), 32'd0);
        if (c == 8 || c == 9) checkOutput("early_grant0", 32'(sGrant), 32'd0);
      end
      checkOutput("early_count", 32'(fifoQ.size()), 32'd5);
      for (int j = 0; j < 5 && j < fifoQ.size(); j++)
        checkOutput("early_fifo", fifoQ[j], expData[j]);
    end

    $display("[TB] reset mid-burst");
    resetDut();
    for (int k = 0; k < 4; k++) pushBeat(3, 32'h30 + k);
    for (int c = 0; c < 3; c++) begin
      applyStimulus(1'b0);
      if (c > 0) begin
        checkOutput("mid_grant3", 32'(sGrant), 32'd3);
        checkOutput("mid_din",    sDin,        32'h30 + c - 1);
      end
    end
    applyStimulus(1'b1);
    pushBeat(0, 32'h60);
    applyStimulus(1'b0);
    checkOutput("mid_busy",  32'(sBusy),  32'd0);
    checkOutput("mid_wr",    32'(sWr),    32'd0);
    checkOutput("mid_ready", 32'(sReady), 32'd0);
    applyStimulus(1'b0);
    checkOutput("mid_regrant", 32'(sGrant), 32'd0);
    checkOutput("mid_wr0",     32'(sWr),    32'd1);
    checkOutput("mid_din0",    sDin,        32'h60);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
